// File: rtl/debug_print_pkg.sv
// debug_print_pkg: shared state, character constants and default attribute for the register dump printer
package debug_print_pkg;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_EMIT, S_DONE} state_t;
    localparam int LABEL_LEN = 5;
    localparam logic [7:0] CH_X = 8'h78;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [23:0] DEF_ATTR = 24'hFFFFFF;
endpackage

// File: rtl/hex_ascii_encoder.sv
// hex_ascii_encoder: nibble to uppercase ASCII hex digit
module hex_ascii_encoder
    import debug_print_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii
);
    always_comb ascii = (nib < 4'd10) ? CH_ZERO + {4'd0, nib} : CH_A + {4'd0, nib} - 8'd10;
endmodule

// File: rtl/reg_dump_printer.sv
// reg_dump_printer: streams a register range as ASCII hex rows into the character buffer
module reg_dump_printer
    import debug_print_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS = 32,
    parameter int COLS = 80,
    parameter int ADDR_W = 13,
    parameter logic [23:0] ATTR = DEF_ATTR,
    localparam int RW = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RW-1:0]        first_reg,
    input  logic [RW-1:0]        last_reg,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 label_en,
    output logic                 busy,
    output logic                 done,
    output logic [RW-1:0]        debug_reg,
    input  logic [WORD_SIZE-1:0] debug_reg_out,
    output logic                 ascii_write_en,
    input  logic                 ascii_write_ready,
    output logic [ADDR_W-1:0]    ascii_write_address,
    output logic [31:0]          ascii_input
);
    localparam int ND = WORD_SIZE / 4;
    localparam int CW = $clog2(ND + LABEL_LEN + 1);

    state_t state, nxt;
    logic [RW-1:0] cur, last_q;
    logic [ADDR_W-1:0] base_q, row_off;
    logic label_q;
    logic [WORD_SIZE-1:0] sh;
    logic [CW-1:0] col, row_len;
    logic emit, fire, last_char, in_label;
    logic [6:0] cur7;
    logic [3:0] tens, units, nib;
    logic [7:0] enc, ch;

    hex_ascii_encoder u_enc (.nib(nib), .ascii(enc));

    // cur never exceeds 99, so a 7-bit divide-by-10 covers the label digits
    always_comb begin
        cur7 = 7'(cur);
        tens = 4'(cur7 / 7'd10);
        units = 4'(cur7 % 7'd10);
        row_len = label_q ? CW'(ND + LABEL_LEN) : CW'(ND);
        in_label = label_q && col < CW'(LABEL_LEN);
        nib = in_label ? (col == CW'(1) ? tens : units) : sh[WORD_SIZE-1 -: 4];
        ch = !in_label ? enc :
             col == CW'(0) ? CH_X :
             col == CW'(3) ? CH_COLON :
             col == CW'(4) ? CH_SPACE : enc;
        emit = state == S_EMIT;
        fire = emit && ascii_write_ready;
        last_char = col == row_len - CW'(1);
    end

    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    assign debug_reg = cur;
    assign ascii_write_en = emit;
    assign ascii_write_address = emit ? base_q + row_off + ADDR_W'(col) : '0;
    assign ascii_input = emit ? {ch, ATTR} : '0;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = start ? (first_reg > last_reg ? S_DONE : S_READ) : S_IDLE;
            S_READ:  nxt = S_LATCH;
            S_LATCH: nxt = S_EMIT;
            S_EMIT:  nxt = fire && last_char ? (cur == last_q ? S_DONE : S_READ) : S_EMIT;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cur <= '0;
            last_q <= '0;
            base_q <= '0;
            row_off <= '0;
            label_q <= 1'b0;
            sh <= '0;
            col <= '0;
        end else if (state == S_IDLE && start) begin
            cur <= first_reg;
            last_q <= last_reg;
            base_q <= base_addr;
            label_q <= label_en;
            row_off <= '0;
        end else if (state == S_LATCH) begin
            sh <= debug_reg_out;
            col <= '0;
        end else if (fire) begin
            col <= col + CW'(1);
            if (!in_label) sh <= {sh[WORD_SIZE-5:0], 4'd0};
            if (last_char && cur != last_q) begin
                cur <= cur + RW'(1);
                row_off <= row_off + ADDR_W'(COLS);
            end
        end
endmodule

// File: tb/tb_reg_dump_printer.sv
// tb_reg_dump_printer: directed dumps with a write scoreboard and an independent monitor
module tb_reg_dump_printer;
    logic clk = 0, rst = 0, start = 0, label_en = 0, ascii_write_ready = 1;
    logic [4:0] first_reg = 0, last_reg = 0, debug_reg;
    logic [12:0] base_addr = 0, ascii_write_address;
    logic busy, done, ascii_write_en;
    logic [31:0] debug_reg_out, ascii_input;
    logic [31:0] regs [32];
    logic [44:0] exp_q [$];
    int checks = 0, failures = 0, cyc = 0;
    bit sb_off = 0, held = 0;
    logic [12:0] held_addr;
    logic [31:0] held_data;

    reg_dump_printer dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
        .base_addr(base_addr), .label_en(label_en), .busy(busy), .done(done),
        .debug_reg(debug_reg), .debug_reg_out(debug_reg_out), .ascii_write_en(ascii_write_en),
        .ascii_write_ready(ascii_write_ready), .ascii_write_address(ascii_write_address),
        .ascii_input(ascii_input)
    );

    assign debug_reg_out = regs[debug_reg];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_str(input int addr, input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({13'(addr + i), s[i], 24'hFFFFFF});
    endtask

    always @(negedge clk) begin
        if (sb_off) held = 0;
        else begin
            if (held) begin
                chk("stall_en", ascii_write_en, 1);
                chk("stall_addr", ascii_write_address, held_addr);
                chk("stall_data", ascii_input, held_data);
            end
            if (ascii_write_en && ascii_write_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual=%0h/%0h required=none", ascii_write_address, ascii_input);
                end else begin
                    logic [44:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", ascii_write_address, e[44:32]);
                    chk("wr_data", ascii_input, e[31:0]);
                end
            end
            held = ascii_write_en && !ascii_write_ready;
            held_addr = ascii_write_address;
            held_data = ascii_input;
        end
    end

    task automatic run(input logic [4:0] f, input logic [4:0] l, input logic [12:0] b,
                       input logic lab, input int exp_cyc, input bit tog);
        int k, bc;
        bit seen;
        @(posedge clk); #1;
        first_reg = f; last_reg = l; base_addr = b; label_en = lab; start = 1;
        k = cyc; bc = 0; seen = 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(posedge clk); #1;
            start = (n == 3);
            if (n == 0) begin
                first_reg = 5'd31; last_reg = 5'd0; base_addr = 13'h1555; label_en = !lab;
            end
            if (tog) ascii_write_ready = (n % 4 == 0) || (n % 4 == 3);
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                seen = 1;
                if (exp_cyc >= 0) begin
                    chk("done_cycle", cyc - k, exp_cyc);
                    chk("busy_cycles", bc, exp_cyc);
                end
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        start = 0;
        ascii_write_ready = 1;
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[0] = 32'hCAFEF00D;
        regs[1] = 32'h01234567;
        regs[2] = 32'h89ABCDEF;
        regs[5] = 32'hDEADBEEF;
        regs[10] = 32'h0000001A;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", ascii_write_en, 0);
        chk("rst_addr", ascii_write_address, 0);
        chk("rst_data", ascii_input, 0);
        chk("rst_dbg", debug_reg, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        push_str(40, "DEADBEEF");
        run(5, 5, 40, 0, 11, 0);

        push_str(100, "x09: 00000000");
        push_str(180, "x10: 0000001A");
        run(9, 10, 100, 1, 31, 0);

        push_str(300, "x01: 01234567");
        run(1, 1, 300, 1, -1, 1);

        run(7, 3, 50, 0, 1, 0);

        push_str(8190, "89ABCDEF");
        run(2, 2, 8190, 0, 11, 0);

        sb_off = 1;
        run(0, 31, 0, 0, 321, 0);

        @(posedge clk); #1;
        first_reg = 0; last_reg = 3; base_addr = 0; label_en = 0; start = 1;
        @(posedge clk); #1 start = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ascii_write_en && ascii_write_address == 13'd162) break;
        end
        chk("rst_reached_row2", ascii_write_address, 162);
        #2 rst = 0;
        #1;
        chk("arst_en", ascii_write_en, 0);
        chk("arst_addr", ascii_write_address, 0);
        chk("arst_data", ascii_input, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dbg", debug_reg, 0);
        @(posedge clk); #1 rst = 1;
        exp_q.delete();
        sb_off = 0;
        push_str(0, "01234567");
        run(1, 1, 0, 0, 11, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_dump_printer.md
# reg_dump_printer

Parametrised register-file dump engine that renders a selectable range of registers as rows of ASCII hex text in the character buffer of the ASCII/VGA controller. It replaces the processor's inline debug-print states with a start/busy/done block. The processor pulses `start` between instructions and waits for `done`. The block reads registers through the register file's debug read port and streams `{char, attribute}` words to the controller one character at a time, under a ready handshake.

## Interface
- `WORD_SIZE`, 32, register width in bits; must be a multiple of 4. Hex digits per row `ND = WORD_SIZE/4`.
- `NUM_REGS`, 32, registers addressable; 2..100. Register index width `RW = clog2(NUM_REGS)`.
- `COLS`, 80, character-buffer row stride.
- `ADDR_W`, 13, character-buffer address width.
- `ATTR`, 24'hFFFFFF, attribute bits placed below each character.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a dump; honoured only in IDLE.
- `first_reg`  in  RW  first register to print; sampled at start.
- `last_reg`  in  RW  last register to print, inclusive; sampled at start.
- `base_addr`  in  ADDR_W  buffer address of row 0, column 0; sampled at start.
- `label_en`  in  1  prefix each row with `xNN: `; sampled at start.
- `busy`  out  1  high from the cycle after start is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse when the dump completes.
- `debug_reg`  out  RW  register index driven to the register file's debug port.
- `debug_reg_out`  in  WORD_SIZE  combinational read data for `debug_reg`.
- `ascii_write_en`  out  1  character write request.
- `ascii_write_ready`  in  1  controller accepts the write this cycle.
- `ascii_write_address`  out  ADDR_W  buffer address.
- `ascii_input`  out  32  `{char[7:0], ATTR}`.

## Operation
- All outputs reset to 0. The state resets to IDLE.
- States are IDLE, READ, LATCH, EMIT, DONE.
- **IDLE.** When `start` is high, capture the inputs and set `cur = first_reg`, `row = 0`.
  - If `first_reg > last_reg`, go to DONE.
  - Otherwise go to READ.
- **READ.** Drive `debug_reg = cur`.
- **LATCH.** Capture `debug_reg_out` into the shift register. Set `col = 0`.
- **EMIT.**
  - Row length: `L = ND + (label_en ? 5 : 0)`.
  - Characters in order:
    - When labelled, first `'x'`, then the tens digit of `cur`, the units digit of `cur`, `':'`, `' '`.
    - Then hex digits, most-significant nibble first.
  - Hex encoding: 0-9 map to 8'h30-8'h39; A-F map to 8'h41-8'h46, uppercase.
  - Address: `base_addr + row*COLS + col`, computed modulo 2^ADDR_W with silent wrap.
  - A character is consumed when `ascii_write_en && ascii_write_ready`. On consumption, `col` increments.
  - After the final character of a row:
    - If `cur == last_reg`, go to DONE.
    - Otherwise increment `cur` and `row` and go to READ.
- **DONE.** Pulse `done`. Return to IDLE.
- `start` during busy is ignored.
- Input changes during busy have no effect.
- Asserting `rst` mid-dump clears `ascii_write_en` immediately. No partial handshake completes.

## Timing
- Cycle 0: `start` is sampled high in IDLE.
  - Cycle 1: READ, `busy` = 1.
  - Cycle 2: LATCH.
  - From cycle 3: EMIT.
- With `ascii_write_ready` held at 1, each row costs `2 + L` cycles.
  - Defaults, no label: 10 cycles per row. A dump of x0..x31 emits 256 characters and pulses `done` at cycle 321.
- Empty range: `done` pulses at cycle 1.
- While `ascii_write_en` = 1 and `ascii_write_ready` = 0:
  - `ascii_write_address`, `ascii_input` and `ascii_write_en` hold stable.
  - The stall is unbounded.
- `ascii_write_en` is low in READ, LATCH, DONE and IDLE.
- `debug_reg` holds `cur` from READ through the end of the row.

## Structure
- Package `debug_print_pkg`:
  - state enum;
  - `LABEL_LEN = 5`;
  - ASCII constants `'x'`, `':'`, `' '`, `'0'`, `'A'`;
  - default `ATTR`.
- Sub-module `hex_ascii_encoder`: 4-bit nibble to 8-bit ASCII, combinational. Also used for decimal digits, which are 0-9.
- Decimal label digits come from a small divide-by-10 of `cur`. Its width is bounded by `NUM_REGS ≤ 100`.
- `row*COLS` uses an incremental accumulator that adds `COLS` per row. No multiplier.

## Test plan
- Dump x5..x5 with defaults, reg = 32'hDEADBEEF, label off, ready = 1 -> 8 writes, chars `D E A D B E E F` at `base_addr+0..7`, each `ascii_input = {char, 24'hFFFFFF}`; `done` at cycle 11.
- Dump x9..x10 with label on, `base_addr` = 100, x9 = 0, x10 = 32'h0000001A:
  - Row 0 at 100..112 reads `x09: 00000000`.
  - Row 1 at 180..192 reads `x10: 0000001A`.
- `ascii_write_ready` toggles 1,0,0,1 during EMIT -> address and data are held through the low cycles, and no character is duplicated or dropped.
- `first_reg = 7`, `last_reg = 3` -> no writes; `done` at cycle 1, `busy` high for exactly one cycle.
- `base_addr = 8190` with `ADDR_W = 13` -> the third character wraps to address 0.
- `rst` asserted during EMIT of row 2, then `start` is applied again -> all outputs are 0 at once, and the next dump restarts from row 0 with correct addresses.
